// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder: default geometry, command opcodes and FSM encoding.
package adc_spi_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NUM_CH_DEF = 8;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_SET_CH = 3'b001;
  localparam logic [2:0] OP_SEQ    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/adc_spi_if.sv
// Three-wire ADC SPI link (frame select, command in, sample out) between master and responder.
interface adc_spi_if;
  logic SYNC1;
  logic SDI1;
  logic SDO1;

  modport master (output SYNC1, output SDI1, input SDO1);
  modport slave  (input SYNC1, input SDI1, output SDO1);
endinterface

// File: rtl/adc_spi_shift.sv
// Bidirectional shift pair: parallel-loaded transmit register, serial receive register, bit counter.
module adc_spi_shift #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              sdi,
  input  logic [DATA_W-1:0] load_data,
  output logic              tx_next_bit,
  output logic [DATA_W-1:0] rx_word,
  output logic [CNT_W-1:0]  bit_cnt
);

  logic [DATA_W-1:0] tx_r;
  // Only DATA_W-1 bits are kept; the final bit comes straight from sdi on the capturing edge.
  logic [DATA_W-2:0] rx_r;
  logic [CNT_W-1:0]  cnt_r;

  assign rx_word     = {rx_r, sdi};
  assign tx_next_bit = tx_r[DATA_W-2];
  assign bit_cnt     = cnt_r;

  // Shift registers and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_r  <= '0;
      rx_r  <= '0;
      cnt_r <= '0;
    end else if (load) begin
      tx_r  <= load_data;
      rx_r  <= rx_word[DATA_W-2:0];
      cnt_r <= CNT_W'(1);
    end else if (shift) begin
      tx_r  <= tx_r << 1;
      rx_r  <= rx_word[DATA_W-2:0];
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      tx_r  <= tx_r;
      rx_r  <= rx_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI target emulating a multichannel ADC: frames on SYNC1, commands in on SDI1, samples out on SDO1.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     SCLK,
  input  logic                     RST,
  adc_spi_if.slave                 spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [CH_W-1:0]          cur_ch,
  output logic [DATA_W-1:0]        cmd_word,
  output logic                     cmd_valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t             state_r, state_nx_s;
  logic               load_s, shift_s, done_s, abort_s;
  logic               tx_next_bit_s;
  logic [DATA_W-1:0]  rx_word_s, snap_s;
  logic [CNT_W-1:0]   bit_cnt_s;
  logic               sdo_r, seq_mode_r, seq_mode_nx_s;
  logic [CH_W-1:0]    cur_ch_r, cur_ch_nx_s, ch_sel_s, seq_adv_s;
  logic [2:0]         opcode_s;
  logic [DATA_W-1:0]  cmd_word_r;
  logic               cmd_valid_r, frame_err_r;

  assign snap_s    = ch_data[cur_ch_r*DATA_W +: DATA_W];
  assign spi.SDO1  = sdo_r;
  assign cur_ch    = cur_ch_r;
  assign cmd_word  = cmd_word_r;
  assign cmd_valid = cmd_valid_r;
  assign frame_err = frame_err_r;
  assign busy      = (state_r == ST_SHIFT);

  adc_spi_shift #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
    .clk         (SCLK),
    .rst         (RST),
    .load        (load_s),
    .shift       (shift_s),
    .sdi         (spi.SDI1),
    .load_data   (snap_s),
    .tx_next_bit (tx_next_bit_s),
    .rx_word     (rx_word_s),
    .bit_cnt     (bit_cnt_s)
  );

  // State register; a reset that lands mid-frame parks in WAIT_HIGH so the partial frame is never answered.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_r <= spi.SYNC1 ? ST_IDLE : ST_WAIT_HIGH;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!spi.SYNC1) begin
          load_s     = 1'b1;
          state_nx_s = ST_SHIFT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (spi.SYNC1) begin
          abort_s    = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          shift_s = 1'b1;
          if (bit_cnt_s == LAST_CNT) begin
            done_s     = 1'b1;
            state_nx_s = ST_WAIT_HIGH;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (spi.SYNC1) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Command decode on the word completing this edge; reserved opcodes behave as NOP.
  always_comb begin
    opcode_s      = rx_word_s[DATA_W-1 -: 3];
    ch_sel_s      = CH_W'(32'(rx_word_s[CH_W-1:0]) % NUM_CH);
    cur_ch_nx_s   = cur_ch_r;
    seq_mode_nx_s = seq_mode_r;
    if (!seq_mode_r) begin
      seq_adv_s = cur_ch_r;
    end else if (cur_ch_r == CH_W'(NUM_CH - 1)) begin
      seq_adv_s = '0;
    end else begin
      seq_adv_s = cur_ch_r + CH_W'(1);
    end
    case (opcode_s)
      OP_NOP:    cur_ch_nx_s = seq_adv_s;
      OP_SET_CH: begin
        cur_ch_nx_s   = ch_sel_s;
        seq_mode_nx_s = 1'b0;
      end
      OP_SEQ:    begin
        cur_ch_nx_s   = ch_sel_s;
        seq_mode_nx_s = 1'b1;
      end
      default:   cur_ch_nx_s = seq_adv_s;
    endcase
  end

  // Serial output: sample MSB on frame start, next bit each shift edge, zero otherwise.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      sdo_r <= 1'b0;
    end else if (load_s) begin
      sdo_r <= snap_s[DATA_W-1];
    end else if (shift_s) begin
      sdo_r <= tx_next_bit_s;
    end else begin
      sdo_r <= 1'b0;
    end
  end

  // Command state and status pulses; cur_ch changes only when a frame completes.
  always_ff @(posedge SCLK) begin
    if (RST) begin
      cur_ch_r    <= '0;
      seq_mode_r  <= 1'b0;
      cmd_word_r  <= '0;
      cmd_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      cmd_valid_r <= done_s;
      frame_err_r <= abort_s;
      if (done_s) begin
        cmd_word_r <= rx_word_s;
        cur_ch_r   <= cur_ch_nx_s;
        seq_mode_r <= seq_mode_nx_s;
      end else begin
        cmd_word_r <= cmd_word_r;
        cur_ch_r   <= cur_ch_r;
        seq_mode_r <= seq_mode_r;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Scoreboard bench for adc_spi_responder: stimulus queues expected SDO bits and events, a monitor checks them.
module tb_adc_spi_responder;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int CW = 3;

  typedef struct packed {
    logic [DW-1:0] cmd;
    logic [CW-1:0] ch;
  } ev_t;

  logic              SCLK = 1'b0;
  logic              RST;
  logic [NC*DW-1:0]  ch_data;
  logic [CW-1:0]     cur_ch;
  logic [DW-1:0]     cmd_word;
  logic              cmd_valid;
  logic              frame_err;
  logic              busy;

  int  tests = 0;
  int  fails = 0;
  bit  edge_low = 1'b0;
  bit  sdo_q[$];
  ev_t cmd_q[$];
  ev_t err_q[$];

  adc_spi_if spi ();

  adc_spi_responder #(.DATA_W(DW), .NUM_CH(NC), .CH_W(CW)) dut (
    .SCLK      (SCLK),
    .RST       (RST),
    .spi       (spi),
    .ch_data   (ch_data),
    .cur_ch    (cur_ch),
    .cmd_word  (cmd_word),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // Remember whether the frame was active at this edge so the monitor knows an SDO bit is due.
  always @(posedge SCLK) edge_low <= !spi.SYNC1;

  // Monitor: compares SDO bits and cmd_valid / frame_err events against the queues.
  always @(negedge SCLK) begin
    bit  eb;
    ev_t ev;
    if (edge_low) begin
      tests++;
      if (sdo_q.size() == 0) begin
        fails++;
        $display("FAIL sdo_unexpected: got bit %0b with no expected bit queued", spi.SDO1);
      end else begin
        tests--;
        eb = sdo_q.pop_front();
        check("sdo_bit", 32'(spi.SDO1), 32'(eb));
      end
    end
    if (cmd_valid === 1'b1) begin
      if (cmd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL cmd_valid_spurious: got pulse with cmd_word %0h, expected none", cmd_word);
      end else begin
        ev = cmd_q.pop_front();
        check("cmd_word", 32'(cmd_word), 32'(ev.cmd));
        check("cur_ch_after_cmd", 32'(cur_ch), 32'(ev.ch));
      end
    end
    if (frame_err === 1'b1) begin
      if (err_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_err_spurious: got pulse, expected none");
      end else begin
        ev = err_q.pop_front();
        check("err_cmd_word_kept", 32'(cmd_word), 32'(ev.cmd));
        check("err_cur_ch_kept", 32'(cur_ch), 32'(ev.ch));
      end
    end
  end

  // One frame of nbits edges; exp_ch / nxt_ch / prev_cmd are hand-derived for each call.
  task automatic frame(input logic [DW-1:0] cmd, input int nbits, input int exp_ch,
                       input logic [CW-1:0] nxt_ch, input logic [DW-1:0] prev_cmd, input bit mutate);
    logic [DW-1:0] snap;
    ev_t ev;
    snap = ch_data[exp_ch*DW +: DW];
    if (nbits >= DW) begin
      ev.cmd = cmd;
      ev.ch  = nxt_ch;
      cmd_q.push_back(ev);
    end else begin
      ev.cmd = prev_cmd;
      ev.ch  = nxt_ch;
      err_q.push_back(ev);
    end
    for (int i = 0; i < nbits; i++) begin
      spi.SYNC1 = 1'b0;
      spi.SDI1  = (i < DW) ? cmd[DW-1-i] : 1'b1;
      sdo_q.push_back((i < DW) ? snap[DW-1-i] : 1'b0);
      if (mutate && i == 4) ch_data[exp_ch*DW +: DW] = ~snap;
      tick();
      if (i == 2) check("busy_in_shift", 32'(busy), 32'd1);
    end
    spi.SYNC1 = 1'b1;
    spi.SDI1  = 1'b0;
    if (mutate) ch_data[exp_ch*DW +: DW] = snap;
    tick();
  endtask

  initial begin
    logic [DW-1:0] snap;
    logic [DW-1:0] rcmd;
    rcmd      = 16'h2007;
    RST       = 1'b1;
    spi.SYNC1 = 1'b1;
    spi.SDI1  = 1'b0;
    ch_data   = {16'hBEEF, 16'hC0DE, 16'h1234, 16'h6978, 16'h4B5A, 16'h2D3C, 16'h0F1E, 16'hA5C3};
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_sdo", 32'(spi.SDO1), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_word", 32'(cmd_word), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    frame(16'h2005, 16, 0, 3'd5, 16'h0000, 1'b0);
    frame(16'h4006, 16, 5, 3'd6, 16'h2005, 1'b1);
    frame(16'h0000, 16, 6, 3'd7, 16'h4006, 1'b0);
    frame(16'h0000, 16, 7, 3'd0, 16'h0000, 1'b0);
    frame(16'h0000, 16, 0, 3'd1, 16'h0000, 1'b0);
    frame(16'h0000, 16, 1, 3'd2, 16'h0000, 1'b0);
    frame(16'hE0FF, 16, 2, 3'd3, 16'h0000, 1'b0);
    frame(16'h2001, 9,  3, 3'd3, 16'hE0FF, 1'b0);
    frame(16'h200A, 16, 3, 3'd2, 16'hE0FF, 1'b0);
    frame(16'h0000, 16, 2, 3'd2, 16'h200A, 1'b0);
    frame(16'h2004, 20, 2, 3'd4, 16'h0000, 1'b0);

    // Reset at bit 7 of a frame from channel 4, SYNC1 held low afterwards.
    snap = ch_data[4*DW +: DW];
    for (int i = 0; i < 7; i++) begin
      spi.SYNC1 = 1'b0;
      spi.SDI1  = rcmd[DW-1-i];
      sdo_q.push_back(snap[DW-1-i]);
      tick();
    end
    RST = 1'b1;
    sdo_q.push_back(1'b0);
    tick();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      spi.SDI1 = 1'b1;
      sdo_q.push_back(1'b0);
      tick();
      if (i == 0 || i == 11) check("busy_wait_high_after_rst", 32'(busy), 32'd0);
    end
    spi.SYNC1 = 1'b1;
    tick();
    check("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
    check("mid_rst_cmd_word", 32'(cmd_word), 32'd0);

    frame(16'h4007, 16, 0, 3'd7, 16'h0000, 1'b0);
    frame(16'h0000, 16, 7, 3'd0, 16'h4007, 1'b0);

    repeat (3) tick();
    check("sdo_q_drained", 32'(sdo_q.size()), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
